uart_cmd_decoder: RTL and testbench
===================================

# uart_cmd_decoder

Converts bytes received by the UART receiver into button pulses and switch toggles for the stopwatch/watch core, and echoes each received byte back to the UART transmitter. It sits between `uart_rx` (upstream) and the `stopwatch_watch` control inputs (downstream). Physical buttons and switches are merged with the UART-generated controls inside this block.

## Interface

**Parameters**
- `PULSE_LEN`, default 1_000_000: cycles each UART-generated button pulse is held high (10 ms at 100 MHz). Must be ≥ 1.
- `ECHO_EN`, default 1: 1 means every accepted byte is echoed; 0 means `tx_start` is tied low.

**Ports**
- `clk` input 1: system clock, 100 MHz.
- `reset` input 1: synchronous, active-high.
- `rx_data` input 8: received byte; valid only while `rx_done`=1.
- `rx_done` input 1: one-cycle strobe from `uart_rx`.
- `btn_r_in`, `btn_l_in`, `btn_u_in`, `btn_d_in` input 1 each: physical buttons.
- `sw_in` input 5: physical switches.
- `tx_busy` input 1: from `uart_tx`.
- `btn_r`, `btn_l`, `btn_u`, `btn_d` output 1 each: merged button outputs.
- `cmd_s` output 1: spare status-request pulse, PULSE_LEN cycles long.
- `sw_out` output 5: merged switch outputs.
- `tx_data` output 8: echo byte.
- `tx_start` output 1: one-cycle transmit request.
- `echo_drop` output 1: sticky flag, set when an echo is lost.

## Operation

**Command map** (lowercase only; all other bytes are ignored for control but still echoed):
- `r`, `l`, `u`, `d` (0x72, 0x6C, 0x75, 0x64): start the pulse for `btn_r`, `btn_l`, `btn_u`, `btn_d` respectively.
- `s` (0x73): start the `cmd_s` pulse.
- `0`–`4` (0x30–0x34): toggle `sw_uart[n]`.

**Merging**
- `btn_x = btn_x_in | pulse_x`.
- `sw_out = sw_in ^ sw_uart`. A UART toggle therefore inverts the current physical switch sense.

**Pulse engines**
- There are five independent down-counters, one per pulse output. Counter width is `$clog2(PULSE_LEN+1)`.
- A matching command loads `PULSE_LEN`. The pulse is high while the counter is nonzero.
- A repeat command during an active pulse reloads the counter. The pulse is extended, not doubled, and shows no low gap.
- Commands for different buttons overlap freely.

**Echo FSM** (only when `ECHO_EN`=1; a one-byte holding buffer `ebuf`, valid flag `ev`)
- `E_IDLE`: if `ev` and `!tx_busy`, assert `tx_start` and go to `E_WAIT`.
- `E_WAIT`: wait for `tx_busy`=1, then go to `E_BUSY`. `uart_tx` raises busy the cycle after `tx_start`.
- `E_BUSY`: on `tx_busy`=0, clear `ev` and go to `E_IDLE`.
- `ev` set by an accepted byte in `E_IDLE`: the byte loads `ebuf` and sets `ev`.
- `ev` set in any other state: the byte overwrites nothing, is dropped from echo, and sets `echo_drop`. Control decode is unaffected.
- `tx_data = ebuf`, held stable from `tx_start` through `E_BUSY`.

**Reset** (any cycle, including mid-pulse or mid-echo)
- All counters cleared, `sw_uart` = 0, `ev` = 0, `echo_drop` = 0, FSM in `E_IDLE`.
- Output values: `btn_x = btn_x_in`, `sw_out = sw_in`, `cmd_s` = 0, `tx_start` = 0, `tx_data` = 0.

## Timing
- Cycle N has `rx_done`=1 with byte `r`. `pulse_r` is high on cycles N+1 … N+PULSE_LEN and low on N+PULSE_LEN+1.
- A toggle on cycle N is visible on `sw_out` at N+1.
- Echo: `tx_start` rises at N+1 if `tx_busy`=0 at N; otherwise on the first cycle after `tx_busy` is seen low.
- Inputs go to outputs combinationally only through the OR/XOR merge. All state is registered.
- `rx_done` on consecutive cycles: each byte is decoded. Only the first is echoed; the rest set `echo_drop`.
- `reset` and `rx_done` in the same cycle: reset wins and the byte is discarded.

## Structure
- Shared package `uart_cmd_pkg`: the ASCII command constants (`CMD_R`, `CMD_L`, `CMD_U`, `CMD_D`, `CMD_S`, `CMD_SW0`–`CMD_SW4`) and the echo state encoding.
- Sub-module `cmd_pulse_gen`, instantiated five times: counter, load, and `PULSE_LEN` parameter.
- Decode, switch register, and echo FSM stay in the top module.

## Test plan
Run with `PULSE_LEN`=8.
- Reset check: hold `reset` 10 cycles with `sw_in`=5'b10101 → `sw_out`=5'b10101, all pulses 0, `tx_start`=0, `echo_drop`=0.
- Button pulse length: send `r` → `btn_r` high exactly 8 cycles starting at N+1, echo of 0x72 with one `tx_start`. Send `r` again at pulse cycle 5 → `btn_r` stays high with no gap until 8 cycles after the second strobe.
- Switch toggles: send `0`, `1`, `2` with `sw_in`=5'b10000 → `sw_out`=5'b10111. Send `1` again → 5'b10101.
- Unknown bytes: send `x` (0x78) and `R` (0x52) → no pulse or toggle change, both echoed.
- Echo overflow: send `u` then `d` while `tx_busy` is held high → 0x75 sent after busy falls; `btn_d` still pulses; `echo_drop`=1 and stays set until reset.
- Reset mid-operation: assert `reset` on pulse cycle 3 and during `E_BUSY` → `btn_l` low next cycle, `sw_uart` cleared, FSM in `E_IDLE`, no `tx_start` afterwards.

Source files
------------

// File: rtl/uart_cmd_decoder_pkg.sv
// Shared constants for the UART command decoder:
// ASCII command bytes and echo FSM encoding.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_R   = 8'h72;
  localparam logic [7:0] CMD_L   = 8'h6C;
  localparam logic [7:0] CMD_U   = 8'h75;
  localparam logic [7:0] CMD_D   = 8'h64;
  localparam logic [7:0] CMD_S   = 8'h73;
  localparam logic [7:0] CMD_SW0 = 8'h30;
  localparam logic [7:0] CMD_SW1 = 8'h31;
  localparam logic [7:0] CMD_SW2 = 8'h32;
  localparam logic [7:0] CMD_SW3 = 8'h33;
  localparam logic [7:0] CMD_SW4 = 8'h34;

  typedef enum logic [1:0] {
    E_IDLE,
    E_WAIT,
    E_BUSY
  } echo_state_e;

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Byte stream between uart_rx/uart_tx and the
// command decoder.
interface uart_cmd_decoder_if;

  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;

  modport master (
    output rx_data,
    output rx_done,
    output tx_busy,
    input  tx_data,
    input  tx_start
  );

  modport slave (
    input  rx_data,
    input  rx_done,
    input  tx_busy,
    output tx_data,
    output tx_start
  );

endinterface

// File: rtl/uart_cmd_decoder_pulse_gen.sv
// Retriggerable pulse stretcher: load holds the
// output high for PULSE_LEN cycles from the next one.
module cmd_pulse_gen #(
  parameter int PULSE_LEN = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  output logic pulse_o
);

  localparam int W = $clog2(PULSE_LEN + 1);
  localparam logic [W-1:0] LOAD = W'(PULSE_LEN);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = LOAD;
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign pulse_o = (cnt_q != '0);

endmodule

// File: rtl/uart_cmd_decoder.sv
// UART byte -> button pulses / switch toggles,
// merged with physical controls, with byte echo.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int PULSE_LEN = 1_000_000,
  parameter bit ECHO_EN   = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  uart_cmd_decoder_if.slave   bus,
  input  logic                btn_r_in,
  input  logic                btn_l_in,
  input  logic                btn_u_in,
  input  logic                btn_d_in,
  input  logic [4:0]          sw_in,
  output logic                btn_r,
  output logic                btn_l,
  output logic                btn_u,
  output logic                btn_d,
  output logic                cmd_s,
  output logic [4:0]          sw_out,
  output logic                echo_drop
);

  // hit order: r, l, u, d, s
  logic [4:0] hit;
  logic [4:0] pulse;
  logic [4:0] sw_tgl;

  logic [4:0]  sw_uart_q;
  logic [4:0]  sw_uart_d;

  echo_state_e state_q;
  logic        ev_q;
  logic [7:0]  ebuf_q;
  logic        tx_start_q;
  logic        drop_q;

  always_comb begin
    hit    = '0;
    sw_tgl = '0;
    if (bus.rx_done) begin
      unique case (bus.rx_data)
        CMD_R:   hit[0]    = 1'b1;
        CMD_L:   hit[1]    = 1'b1;
        CMD_U:   hit[2]    = 1'b1;
        CMD_D:   hit[3]    = 1'b1;
        CMD_S:   hit[4]    = 1'b1;
        CMD_SW0: sw_tgl[0] = 1'b1;
        CMD_SW1: sw_tgl[1] = 1'b1;
        CMD_SW2: sw_tgl[2] = 1'b1;
        CMD_SW3: sw_tgl[3] = 1'b1;
        CMD_SW4: sw_tgl[4] = 1'b1;
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < 5; i++) begin : g_pulse
    cmd_pulse_gen #(
      .PULSE_LEN (PULSE_LEN)
    ) u_pg (
      .clk     (clk),
      .reset   (reset),
      .load_i  (hit[i]),
      .pulse_o (pulse[i])
    );
  end

  assign sw_uart_d = sw_uart_q ^ sw_tgl;

  always_ff @(posedge clk) begin
    if (reset)
      sw_uart_q <= '0;
    else
      sw_uart_q <= sw_uart_d;
  end

  // A byte arriving in E_IDLE with the buffer empty
  // is sent straight away when the transmitter is free.
  always_ff @(posedge clk) begin
    if (reset || !ECHO_EN) begin
      state_q    <= E_IDLE;
      ev_q       <= 1'b0;
      ebuf_q     <= '0;
      tx_start_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      unique case (state_q)
        E_IDLE: begin
          if (bus.rx_done && !ev_q) begin
            ev_q   <= 1'b1;
            ebuf_q <= bus.rx_data;
          end
          if ((ev_q || bus.rx_done) && !bus.tx_busy) begin
            tx_start_q <= 1'b1;
            state_q    <= E_WAIT;
          end
        end
        E_WAIT: begin
          if (bus.tx_busy)
            state_q <= E_BUSY;
        end
        E_BUSY: begin
          if (!bus.tx_busy) begin
            ev_q    <= 1'b0;
            state_q <= E_IDLE;
          end
        end
        default: state_q <= E_IDLE;
      endcase
      if (bus.rx_done && ev_q)
        drop_q <= 1'b1;
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = ebuf_q;

  assign btn_r     = btn_r_in | pulse[0];
  assign btn_l     = btn_l_in | pulse[1];
  assign btn_u     = btn_u_in | pulse[2];
  assign btn_d     = btn_d_in | pulse[3];
  assign cmd_s     = pulse[4];
  assign sw_out    = sw_in ^ sw_uart_q;
  assign echo_drop = drop_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: transaction-level
// model plus directed literal checks.
module tb_uart_cmd_decoder;

  localparam int PL = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       br, bl, bu, bd;
  logic [4:0] sw_in;
  logic       btn_r, btn_l, btn_u, btn_d, cmd_s;
  logic [4:0] sw_out;
  logic       echo_drop;

  uart_cmd_decoder_if bus();

  always #5 clk = ~clk;

  uart_cmd_decoder #(
    .PULSE_LEN (PL),
    .ECHO_EN   (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .btn_r_in  (br),
    .btn_l_in  (bl),
    .btn_u_in  (bu),
    .btn_d_in  (bd),
    .sw_in     (sw_in),
    .btn_r     (btn_r),
    .btn_l     (btn_l),
    .btn_u     (btn_u),
    .btn_d     (btn_d),
    .cmd_s     (cmd_s),
    .sw_out    (sw_out),
    .echo_drop (echo_drop)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // simple transmitter: busy for 2 cycles after a start
  logic busy_force = 1'b0;
  int   busy_ctr   = 0;
  always @(posedge clk) begin
    if (bus.tx_start === 1'b1)
      busy_ctr <= 2;
    else if (busy_ctr > 0)
      busy_ctr <= busy_ctr - 1;
  end
  assign bus.tx_busy = busy_force | (busy_ctr != 0);

  function automatic int cmd_idx(input logic [7:0] b);
    case (b)
      8'h72:   return 0;
      8'h6C:   return 1;
      8'h75:   return 2;
      8'h64:   return 3;
      8'h73:   return 4;
      default: return -1;
    endcase
  endfunction

  // model state
  int         cyc = 0;
  int         last[5] = '{default: -1000};
  logic [4:0] sw_m = '0;
  bit         drop_m = 0, pend = 0, sent = 0, bseen = 0;
  bit         exp_start = 0, live = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) begin
    int k, n;
    if (reset) begin
      live = 1;
      for (int i = 0; i < 5; i++) last[i] = -1000;
      sw_m = '0;
      drop_m = 0; pend = 0; sent = 0; bseen = 0;
      exp_start = 0;
      exp_q.delete();
    end else begin
      if (bus.tx_start === 1'b1) sent = 1;
      if (bus.rx_done) begin
        k = cmd_idx(bus.rx_data);
        if (k >= 0) last[k] = cyc;
        if (bus.rx_data inside {[8'h30:8'h34]}) begin
          n = int'(bus.rx_data) - 48;
          sw_m[n] = ~sw_m[n];
        end
        if (pend) drop_m = 1;
        else begin
          exp_q.push_back(bus.rx_data);
          pend = 1;
        end
      end
      exp_start = pend && !sent && !bus.tx_busy;
      if (sent) begin
        if (bseen && !bus.tx_busy) begin
          pend = 0; sent = 0; bseen = 0;
        end else if (bus.tx_busy) bseen = 1;
      end
    end
    cyc++;
  end

  int         n_start = 0;
  logic [7:0] last_tx = '0;
  logic [4:0] pe;

  always @(negedge clk) begin
    if (live) begin
      for (int i = 0; i < 5; i++)
        pe[i] = (cyc - last[i] >= 1) && (cyc - last[i] <= PL);
      chk("btn_r", btn_r, br | pe[0]);
      chk("btn_l", btn_l, bl | pe[1]);
      chk("btn_u", btn_u, bu | pe[2]);
      chk("btn_d", btn_d, bd | pe[3]);
      chk("cmd_s", cmd_s, pe[4]);
      chk("sw_out", sw_out, sw_in ^ sw_m);
      chk("echo_drop", echo_drop, drop_m);
      chk("tx_start", bus.tx_start, exp_start);
      if (bus.tx_start === 1'b1) begin
        n_start++;
        last_tx = bus.tx_data;
        if (exp_q.size() > 0)
          chk("tx_data", bus.tx_data, exp_q.pop_front());
        else
          chk("tx_queue", exp_q.size(), 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    tick();
    bus.rx_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int s0, hi, hi2;
    logic ts1;
    br = 0; bl = 0; bu = 0; bd = 0;
    sw_in = 5'b10101;
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
    reset = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    chk("rst_sw_out", sw_out, 5'b10101);
    chk("rst_pulses", {btn_r, btn_l, btn_u, btn_d, cmd_s}, 5'b0);
    chk("rst_tx_start", bus.tx_start, 1'b0);
    chk("rst_echo_drop", echo_drop, 1'b0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    tick();
    reset = 1'b0;
    tick();

    // pulse length and retrigger
    s0 = n_start; hi = 0; hi2 = 0; ts1 = 0;
    send(8'h72);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) ts1 = bus.tx_start;
      hi += int'(btn_r);
      tick();
    end
    send(8'h72);
    repeat (12) begin
      @(negedge clk);
      hi2 += int'(btn_r);
      tick();
    end
    chk("tx_start_N1", ts1, 1'b1);
    chk("btn_r_first", hi, 4);
    chk("btn_r_ext", hi2, 8);
    chk("echo_r_cnt", n_start - s0, 2);
    chk("echo_r", last_tx, 8'h72);

    // switch toggles
    sw_in = 5'b10000;
    tick();
    send(8'h30); repeat (4) tick();
    send(8'h31); repeat (4) tick();
    send(8'h32); repeat (4) tick();
    @(negedge clk);
    chk("sw_012", sw_out, 5'b10111);
    tick();
    send(8'h31); repeat (4) tick();
    @(negedge clk);
    chk("sw_1_again", sw_out, 5'b10101);
    tick();

    // unknown bytes
    s0 = n_start;
    send(8'h78); repeat (5) tick();
    send(8'h52); repeat (5) tick();
    @(negedge clk);
    chk("unk_sw", sw_out, 5'b10101);
    chk("unk_btn", {btn_r, btn_l, btn_u, btn_d, cmd_s}, 5'b0);
    chk("unk_echo_cnt", n_start - s0, 2);
    chk("unk_echo", last_tx, 8'h52);
    tick();

    // echo overflow
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    busy_force = 1'b1;
    s0 = n_start;
    send(8'h75);
    send(8'h64);
    @(negedge clk);
    chk("ovf_btn_u", btn_u, 1'b1);
    chk("ovf_btn_d", btn_d, 1'b1);
    chk("ovf_drop", echo_drop, 1'b1);
    chk("ovf_held", n_start - s0, 0);
    tick();
    repeat (3) tick();
    busy_force = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    chk("ovf_cnt", n_start - s0, 1);
    chk("ovf_data", last_tx, 8'h75);
    chk("ovf_sticky", echo_drop, 1'b1);
    tick();

    // reset mid-pulse
    send(8'h33); repeat (4) tick();
    send(8'h6C);
    tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    @(negedge clk);
    chk("mid_btn_l", btn_l, 1'b0);
    chk("mid_sw", sw_out, 5'b10000);
    chk("mid_drop", echo_drop, 1'b0);
    tick();

    // reset during busy echo
    send(8'h78);
    tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    s0 = n_start;
    repeat (10) tick();
    @(negedge clk);
    chk("busy_rst_nostart", n_start - s0, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
